// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch stage: fetches one word at a time from instruction memory
// and buffers {instruction, PC} pairs in a small FIFO for the core.
module fetch_prefetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] fetch_pc, fetch_pc_next;
    logic [ADDR_W-1:0] req_pc, req_pc_next;
    logic              discard, discard_next;
    logic              push_en;
    logic              pop_en;
    logic [ADDR_W-1:0] redirect_aligned;
    logic              unused_redirect_lsbs;

    logic [31:0]       data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    assign redirect_aligned     = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign mem_req    = (state == REQ);
    assign mem_addr   = req_pc;
    assign inst_valid = (count != '0);
    assign inst_data  = inst_valid ? data_mem[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr] : '0;
    assign pop_en     = inst_valid && inst_ready && !redirect_valid;

    // A request is only launched from IDLE with a free slot, so the single
    // outstanding word always has room when it returns.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_pc_next   = req_pc;
        discard_next  = discard;
        push_en       = 1'b0;
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_next = redirect_aligned;
                end else if (count < FULL_COUNT) begin
                    req_pc_next = fetch_pc;
                    state_next  = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_next    = WAIT;
                    fetch_pc_next = fetch_pc + ADDR_W'(4);
                end
                if (redirect_valid) begin
                    fetch_pc_next = redirect_aligned;
                    discard_next  = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_next   = IDLE;
                    discard_next = 1'b0;
                    push_en      = !discard && !redirect_valid;
                    if (redirect_valid) begin
                        fetch_pc_next = redirect_aligned;
                    end
                end else if (redirect_valid) begin
                    fetch_pc_next = redirect_aligned;
                    discard_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            discard  <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_pc   <= req_pc_next;
            discard  <= discard_next;
        end
    end

    // A redirect empties the buffer outright; any push or pop that cycle is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_en && !pop_en) begin
                count <= count + CNT_W'(1);
            end else if (!push_en && pop_en) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            data_mem[wr_ptr] <= mem_rdata;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit: a memory model checks request addresses,
// a negedge monitor checks every instruction the core accepts.
module tb_fetch_prefetch_unit;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int SEL_DELIVERED = 0;
    localparam int SEL_ACKS      = 1;
    localparam int SEL_RVALIDS   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              inst_valid;
    logic [31:0]       inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_t;

    inst_t       exp_q[$];
    logic [31:0] exp_addr_q[$];
    inst_t       mon_exp;

    int tests_run    = 0;
    int tests_failed = 0;
    int delivered    = 0;
    int ack_count    = 0;
    int rvalid_count = 0;
    int ack_delay    = 0;
    int rvalid_delay = 1;
    int wait_cnt     = 0;
    int resp_timer   = 0;
    bit mem_pending  = 1'b0;
    bit stale_override = 1'b0;
    logic [31:0] resp_addr;

    fetch_prefetch_unit #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0004: return 32'h0010_0093;
            32'h0000_0008: return 32'h0020_0113;
            32'h0000_000C: return 32'h0030_0193;
            32'h0000_0010: return 32'h0040_0213;
            32'h0000_1000: return 32'h1111_1111;
            32'h0000_1004: return 32'h2222_2222;
            32'h0000_2000: return 32'h4444_4444;
            32'h0000_2004: return 32'h5555_5555;
            32'h0000_3000: return 32'h7777_7777;
            32'h0000_3004: return 32'h8888_8888;
            default:       return {16'hBAD0, a[15:0]};
        endcase
    endfunction

    function automatic int counter_of(input int which);
        case (which)
            SEL_DELIVERED: return delivered;
            SEL_ACKS:      return ack_count;
            default:       return rvalid_count;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic pushInst(input logic [31:0] pc, input logic [31:0] data);
        inst_t e;
        e.pc   = pc;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic waitFor(input int which, input int target, input int budget, input string name, output int cycles);
        cycles = 0;
        while (counter_of(which) < target && cycles < budget) begin
            @(posedge clk);
            #2;
            cycles++;
        end
        checkOutput(name, 32'(counter_of(which)), 32'(target));
    endtask

    // Holds the DUT in reset, clears the scoreboards and sets up the memory timing.
    task automatic applyStimulus(input int a_delay, input int r_delay, input logic ready);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        exp_q.delete();
        exp_addr_q.delete();
        delivered      = 0;
        ack_count      = 0;
        rvalid_count   = 0;
        ack_delay      = a_delay;
        rvalid_delay   = r_delay;
        stale_override = 1'b0;
        inst_ready     = ready;
    endtask

    // Memory model: acks after ack_delay cycles of mem_req, answers rvalid_delay cycles later.
    initial begin
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (!rst) begin
                mem_pending = 1'b0;
                wait_cnt    = 0;
            end else if (mem_pending) begin
                if (resp_timer <= 1) begin
                    mem_rvalid     = 1'b1;
                    mem_rdata      = stale_override ? 32'hDEAD_BEEF : mem_word(resp_addr);
                    stale_override = 1'b0;
                    mem_pending    = 1'b0;
                    rvalid_count++;
                end else begin
                    resp_timer--;
                end
            end else if (mem_req) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack     = 1'b1;
                    mem_pending = 1'b1;
                    resp_addr   = mem_addr;
                    resp_timer  = rvalid_delay;
                    wait_cnt    = 0;
                    ack_count++;
                    if (exp_addr_q.size() > 0) begin
                        checkOutput("mem_addr", mem_addr, exp_addr_q.pop_front());
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor: every accepted instruction is popped off the scoreboard and compared.
    always @(negedge clk) begin
        if (rst) begin
            if (inst_valid && inst_ready && !redirect_valid) begin
                delivered++;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_inst: got pc=0x%08h data=0x%08h, required none", inst_pc, inst_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("inst_pc", inst_pc, mon_exp.pc);
                    checkOutput("inst_data", inst_data, mon_exp.data);
                end
            end
            if (mem_pending && !mem_ack) begin
                checkOutput("req_in_wait", 32'(mem_req), 32'h0);
            end
            if (mem_req) begin
                checkOutput("addr_align", 32'(mem_addr[1:0]), 32'h0);
            end
            if (dut.push_en && int'(dut.count) == DEPTH) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL fifo_overflow: got push with count=%0d, required count<%0d", dut.count, DEPTH);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;

        // Reset values, then streaming with zero-wait memory at one word per 3 cycles.
        applyStimulus(0, 1, 1'b1);
        checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("rst_inst_data", inst_data, 32'h0);
        checkOutput("rst_inst_pc", inst_pc, 32'h0);
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        pushInst(32'h0, 32'h0000_0013);
        pushInst(32'h4, 32'h0010_0093);
        pushInst(32'h8, 32'h0020_0113);
        pushInst(32'hC, 32'h0030_0193);
        rst = 1'b1;
        waitFor(SEL_DELIVERED, 4, 60, "s1_delivered", cyc);
        inst_ready = 1'b0;
        checkOutput("s1_cycles", 32'(cyc), 32'd13);
        checkOutput("s1_addr_left", 32'(exp_addr_q.size()), 32'h0);

        // Core stalled: exactly DEPTH words fetched, then one pop frees one request.
        applyStimulus(0, 1, 1'b0);
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        rst = 1'b1;
        waitFor(SEL_RVALIDS, 4, 60, "s2_filled", cyc);
        repeat (10) @(posedge clk);
        #2;
        checkOutput("s2_acks_full", 32'(ack_count), 32'd4);
        checkOutput("s2_req_full", 32'(mem_req), 32'h0);
        checkOutput("s2_head_valid", 32'(inst_valid), 32'h1);
        checkOutput("s2_head_pc", inst_pc, 32'h0);
        pushInst(32'h0, 32'h0000_0013);
        inst_ready = 1'b1;
        @(posedge clk);
        #2;
        inst_ready = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        checkOutput("s2_acks_after_pop", 32'(ack_count), 32'd5);
        checkOutput("s2_req_refull", 32'(mem_req), 32'h0);
        checkOutput("s2_one_pop", 32'(delivered), 32'd1);
        pushInst(32'h4, 32'h0010_0093);
        pushInst(32'h8, 32'h0020_0113);
        pushInst(32'hC, 32'h0030_0193);
        pushInst(32'h10, 32'h0040_0213);
        inst_ready = 1'b1;
        waitFor(SEL_DELIVERED, 5, 60, "s2_drained", cyc);
        inst_ready = 1'b0;
        checkOutput("s2_addr_left", 32'(exp_addr_q.size()), 32'h0);

        // Redirect while waiting on a slow response; the stale word must vanish.
        applyStimulus(0, 3, 1'b1);
        exp_addr_q = '{32'h0, 32'h1000, 32'h1004};
        rst = 1'b1;
        waitFor(SEL_ACKS, 1, 20, "s3_first_ack", cyc);
        @(posedge clk);
        #2;
        checkOutput("s3_in_wait", 32'(mem_req), 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1002;
        stale_override = 1'b1;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        pushInst(32'h1000, 32'h1111_1111);
        pushInst(32'h1004, 32'h2222_2222);
        waitFor(SEL_DELIVERED, 2, 80, "s3_delivered", cyc);
        inst_ready = 1'b0;
        checkOutput("s3_addr_left", 32'(exp_addr_q.size()), 32'h0);

        // Redirect in the ack cycle of the request to 0x8: no PC increment, response dropped.
        applyStimulus(0, 1, 1'b1);
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'h2000, 32'h2004};
        pushInst(32'h0, 32'h0000_0013);
        pushInst(32'h4, 32'h0010_0093);
        rst = 1'b1;
        cyc = 0;
        while (!(mem_req && mem_addr == 32'h8) && cyc < 40) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        checkOutput("s4_req8_seen", mem_addr, 32'h8);
        checkOutput("s4_ack_same_cycle", 32'(mem_ack), 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        pushInst(32'h2000, 32'h4444_4444);
        pushInst(32'h2004, 32'h5555_5555);
        waitFor(SEL_DELIVERED, 4, 80, "s4_delivered", cyc);
        inst_ready = 1'b0;
        checkOutput("s4_addr_left", 32'(exp_addr_q.size()), 32'h0);

        // Flush with three words buffered and the core ready: nothing is popped.
        applyStimulus(0, 1, 1'b0);
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'h3000, 32'h3004};
        rst = 1'b1;
        waitFor(SEL_RVALIDS, 3, 40, "s5_three_words", cyc);
        @(posedge clk);
        #2;
        checkOutput("s5_valid_before", 32'(inst_valid), 32'h1);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
        checkOutput("s5_valid_after_flush", 32'(inst_valid), 32'h0);
        checkOutput("s5_no_pop", 32'(delivered), 32'h0);
        pushInst(32'h3000, 32'h7777_7777);
        pushInst(32'h3004, 32'h8888_8888);
        waitFor(SEL_DELIVERED, 2, 60, "s5_refilled", cyc);
        inst_ready = 1'b0;
        checkOutput("s5_addr_left", 32'(exp_addr_q.size()), 32'h0);

        // Asynchronous reset between edges while a request is held.
        applyStimulus(0, 1, 1'b0);
        exp_addr_q = '{32'h0};
        rst = 1'b1;
        waitFor(SEL_RVALIDS, 1, 20, "s6_first_word", cyc);
        ack_delay = 3;
        cyc = 0;
        while (!mem_req && cyc < 20) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        checkOutput("s6_req_held", 32'(mem_req), 32'h1);
        checkOutput("s6_valid_before", 32'(inst_valid), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("s6_async_mem_req", 32'(mem_req), 32'h0);
        checkOutput("s6_async_inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("s6_async_inst_data", inst_data, 32'h0);
        checkOutput("s6_async_mem_addr", mem_addr, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        exp_addr_q.delete();
        exp_addr_q = '{32'h0, 32'h4};
        ack_delay  = 0;
        inst_ready = 1'b1;
        pushInst(32'h0, 32'h0000_0013);
        pushInst(32'h4, 32'h0010_0093);
        rst = 1'b1;
        waitFor(SEL_DELIVERED, 2, 40, "s6_restart", cyc);
        inst_ready = 1'b0;
        checkOutput("s6_addr_left", 32'(exp_addr_q.size()), 32'h0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction prefetch stage directly upstream of the multicycle core.
- Issues word reads to instruction memory from its own fetch PC and buffers returned words with their PCs in a small FIFO.
- Presents instructions to the core over a valid/ready handshake.
- Flushes and restarts on a redirect from the core (branch, jump, reset vector).

Parameters:
- ADDR_W, 32, byte-address width of the PC and mem_addr.
- DEPTH, 4, FIFO entries (power of two, at least 2).
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_req  output  1  read request to instruction memory.
- mem_addr  output  ADDR_W  word-aligned byte address of request; bits [1:0] always 0.
- mem_ack  input  1  memory accepted the request this cycle.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  32  instruction word.
- inst_valid  output  1  FIFO head valid.
- inst_data  output  32  instruction at FIFO head.
- inst_pc  output  ADDR_W  PC of inst_data.
- inst_ready  input  1  core consumes head this cycle.
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  ADDR_W  new fetch PC; bits [1:0] ignored.

Behaviour:
- Reset (rst=0, asynchronous):
  - mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0.
  - FIFO empty; fetch PC=RESET_PC; state IDLE; discard flag 0.
- At most one outstanding memory transaction. Memory responses are in order and arrive 1 or more cycles after the ack cycle.
- FSM:
  - IDLE: if count+pending < DEPTH (pending=1 only while in WAIT), assert mem_req next cycle with mem_addr=fetch PC -> REQ.
  - REQ: mem_req=1. mem_req and mem_addr are held stable until mem_ack=1. On ack: fetch PC += 4, mem_req drops next cycle -> WAIT.
  - WAIT: on mem_rvalid, push {mem_rdata, request PC} unless the discard flag is set; clear the discard flag -> IDLE.
- Throughput: one instruction every 3 cycles with zero-wait memory (REQ, WAIT, IDLE). Streaming is not required.
- The request is issued only when a FIFO slot is guaranteed, so a push never finds the FIFO full. Overflow is a design error; the bench asserts on it.
- FIFO:
  - Head is visible combinationally on inst_data/inst_pc; inst_valid = (count != 0).
  - Pop when inst_valid && inst_ready. Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - inst_ready while empty is ignored.
  - Entry reaches the head the cycle after its mem_rvalid when the FIFO was empty.
- Redirect (redirect_valid=1), effective at the clock edge:
  - FIFO flushed, count=0, inst_valid=0 next cycle. A simultaneous pop or push is dropped.
  - Fetch PC = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - In REQ without ack: the request completes as issued and its response is discarded (discard flag set).
  - In REQ with ack the same cycle: discard flag set; the PC increment is suppressed.
  - In WAIT without rvalid: discard flag set.
  - In WAIT with rvalid the same cycle: the data is dropped; go to IDLE with the discard flag clear.
  - In IDLE: the new PC is used by the next request.
  - Back-to-back redirects: the last one wins; at most one discard is pending.
- PC arithmetic wraps modulo 2^ADDR_W.
- Reset mid-transaction: all state clears immediately. Memory must tolerate a dropped request.

Test Plan:
- Reset release, memory acks immediately, rvalid 1 cycle later with 0x00000013, 0x00100093, ...; inst_ready=1 -> mem_addr 0x0, 0x4, 0x8...; inst_pc/inst_data pairs match in order; mem_req never high while in WAIT.
- inst_ready=0 with zero-wait memory -> exactly DEPTH=4 words buffered (PCs 0x0-0xC), then mem_req stays 0. One pop -> exactly one new request to 0x10.
- Redirect to 0x1002 while in WAIT; stale rvalid data 0xDEADBEEF arrives -> never presented; next request mem_addr=0x1000; first delivered inst_pc=0x1000.
- Redirect in the same cycle as mem_ack with mem_addr=0x8 -> that response is dropped; next mem_addr equals the redirect PC, not 0xC.
- Redirect with 3 entries buffered and inst_ready=1 -> inst_valid=0 the next cycle; no pop is counted; FIFO refills from the new PC.
- Assert rst=0 mid-REQ, asynchronously between edges -> mem_req and inst_valid drop immediately; after release, first mem_addr=RESET_PC.
